// File: rtl/baugh_wooley_mult_pkg.sv
// Shared definitions for the Baugh-Wooley signed multiplier.
//   BW_N   : default operand width
//   bw_ref : behavioural signed product, for assertions and scoreboards.
//            Callers sign-extend operands to 32 bits and truncate the
//            64-bit result to 2N bits.
package baugh_wooley_mult_pkg;

  localparam int BW_N = 4;

  function automatic logic signed [63:0] bw_ref(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = a;
    eb = b;
    return ea * eb;
  endfunction

endpackage

// File: rtl/baugh_wooley_mult_bw_cell.sv
// One Baugh-Wooley array cell: partial-product gate feeding a full adder.
//   a_bit, b_bit : operand bits forming the partial product
//   inv          : 1 selects NAND, 0 selects AND
//   sum_in       : incoming sum bit at this cell's weight
//   carry_in     : incoming carry bit at this cell's weight
//   sum_out      : sum at this cell's weight
//   carry_out    : carry at the next weight up
module bw_cell
  import baugh_wooley_mult_pkg::*;
(
  input  logic a_bit,
  input  logic b_bit,
  input  logic inv,
  input  logic sum_in,
  input  logic carry_in,
  output logic sum_out,
  output logic carry_out
);

  logic w_pp;

  assign w_pp      = (a_bit & b_bit) ^ inv;
  assign sum_out   = w_pp ^ sum_in ^ carry_in;
  assign carry_out = (w_pp & sum_in) | (w_pp & carry_in) | (sum_in & carry_in);

endmodule

// File: rtl/baugh_wooley_mult.sv
// Signed N x N Baugh-Wooley array multiplier with a registered 2N-bit product.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears p
//   a, b  : signed two's-complement operands, N bits
//   p     : signed product a*b, 2N bits, one cycle of latency
//
// Structure: row 0 is the bare partial-product row, rows 1..N-1 are
// carry-save rows of bw_cell, and a final ripple row of bw_cell resolves the
// remaining sum/carry vectors into the upper N product bits.
module baugh_wooley_mult
  import baugh_wooley_mult_pkg::*;
#(
  parameter int N = BW_N
)
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  logic [N-1:0]   w_pp0;
  logic [2*N-1:0] w_prod;
  logic [2*N-1:0] r_p;
  logic           w_unused_cout;

  // Row 0: pp[0][j]; only the j = N-1 term is inverted here.
  for (genvar j = 0; j < N; j++) begin : g_pp0
    if (j == N-1) begin : g_nand
      assign w_pp0[j] = ~(a[j] & b[0]);
    end else begin : g_and
      assign w_pp0[j] = a[j] & b[0];
    end
  end

  assign w_prod[0] = w_pp0[0];

  // Carry-save rows. Cell (r,j) sits at weight r+j; it takes the sum from the
  // previous row's cell j+1 and the carry from the previous row's cell j.
  // The leftmost cell of row 1 sits at weight N, so the correction constant
  // at bit N enters there as its sum input.
  for (genvar r = 1; r < N; r++) begin : g_row
    logic [N-1:0] w_s;
    logic [N-1:0] w_c;

    for (genvar j = 0; j < N; j++) begin : g_col
      logic w_sin;
      logic w_cin;

      if (r == 1) begin : g_first
        assign w_cin = 1'b0;
        if (j == N-1) begin : g_corr
          assign w_sin = 1'b1;
        end else begin : g_pp
          assign w_sin = w_pp0[j+1];
        end
      end else begin : g_next
        assign w_cin = g_row[r-1].w_c[j];
        if (j == N-1) begin : g_edge
          assign w_sin = 1'b0;
        end else begin : g_sum
          assign w_sin = g_row[r-1].w_s[j+1];
        end
      end

      // NAND exactly when one (not both) of the indices is the sign position.
      bw_cell u_cell (
        .a_bit     (a[j]),
        .b_bit     (b[r]),
        .inv       ((r == N-1) ^ (j == N-1)),
        .sum_in    (w_sin),
        .carry_in  (w_cin),
        .sum_out   (w_s[j]),
        .carry_out (w_c[j])
      );
    end

    assign w_prod[r] = w_s[0];
  end

  // Final ripple row over weights N..2N-1. The top position adds the
  // correction constant at bit 2N-1 in place of a (non-existent) sum bit.
  // The final carry out is weight 2N and drops out modulo 2^2N.
  for (genvar k = 0; k < N; k++) begin : g_rip
    logic w_x;
    logic w_ci;
    logic w_so;
    logic w_co;

    if (k == N-1) begin : g_msb
      assign w_x = 1'b1;
    end else begin : g_low
      assign w_x = g_row[N-1].w_s[k+1];
    end

    if (k == 0) begin : g_lsb
      assign w_ci = 1'b0;
    end else begin : g_chain
      assign w_ci = g_rip[k-1].w_co;
    end

    bw_cell u_fa (
      .a_bit     (w_x),
      .b_bit     (1'b1),
      .inv       (1'b0),
      .sum_in    (g_row[N-1].w_c[k]),
      .carry_in  (w_ci),
      .sum_out   (w_so),
      .carry_out (w_co)
    );

    assign w_prod[N+k] = w_so;
  end

  assign w_unused_cout = g_rip[N-1].w_co;

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= '0;
    end else begin
      r_p <= w_prod;
    end
  end

  assign p = r_p;

endmodule

// File: tb/tb_baugh_wooley_mult.sv
module tb_baugh_wooley_mult;

  logic        clk;
  logic        rst_n;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic [7:0]  p4;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [15:0] p8;

  int n_tot;
  int n_bad;

  baugh_wooley_mult #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a4),
    .b     (b4),
    .p     (p4)
  );

  baugh_wooley_mult #(.N(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a8),
    .b     (b8),
    .p     (p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m4(input logic [3:0] x, input logic [3:0] y);
    logic signed [7:0] sx;
    logic signed [7:0] sy;
    sx = {{4{x[3]}}, x};
    sy = {{4{y[3]}}, y};
    return sx * sy;
  endfunction

  function automatic logic [15:0] m8(input logic [7:0] x, input logic [7:0] y);
    logic signed [15:0] sx;
    logic signed [15:0] sy;
    sx = {{8{x[7]}}, x};
    sy = {{8{y[7]}}, y};
    return sx * sy;
  endfunction

  task automatic dir(input string tag, input logic [3:0] x, input logic [3:0] y,
                     input logic [7:0] exp);
    @(negedge clk);
    a4 = x;
    b4 = y;
    @(posedge clk);
    #1;
    chk(tag, {56'd0, p4}, {56'd0, exp});
  endtask

  initial begin
    logic [7:0]  exp4_q;
    logic [15:0] exp8_q;
    n_tot = 0;
    n_bad = 0;
    rst_n = 1'b0;
    a4 = 4'b1011;
    b4 = 4'b1010;
    a8 = 8'h81;
    b8 = 8'h7F;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_p4", {56'd0, p4}, 64'd0);
    chk("rst_p8", {48'd0, p8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // first load, then asynchronous reset mid-cycle
    dir("m5_m6", 4'b1011, 4'b1010, 8'h1E);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {56'd0, p4}, 64'd0);
    @(negedge clk);
    chk("rst_hold", {56'd0, p4}, 64'd0);
    rst_n = 1'b1;

    dir("neg_neg_a", 4'b1011, 4'b1010, 8'h1E);
    dir("neg_neg_b", 4'b1111, 4'b1111, 8'h01);
    dir("neg_neg_c", 4'b1010, 4'b1110, 8'h0C);
    dir("neg_neg_d", 4'b1001, 4'b1000, 8'h38);
    dir("zero",      4'b1000, 4'b0000, 8'h00);
    dir("mix_a",     4'b0001, 4'b1100, 8'hFC);
    dir("mix_b",     4'b0010, 4'b1110, 8'hFC);
    dir("mix_c",     4'b0011, 4'b1011, 8'hF1);
    dir("mix_d",     4'b0111, 4'b1001, 8'hCF);
    dir("min_min",   4'b1000, 4'b1000, 8'h40);
    dir("max_max",   4'b0111, 4'b0111, 8'h31);
    dir("max_min",   4'b0111, 4'b1000, 8'hC8);

    // back-to-back: new operands every cycle, product checked one cycle later
    exp4_q = '0;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i > 0) chk("b2b", {56'd0, p4}, {56'd0, exp4_q});
      if (i < 20) begin
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        exp4_q = m4(a4, b4);
      end
    end

    // exhaustive N=4
    for (int i = 0; i <= 256; i++) begin
      @(negedge clk);
      if (i > 0) chk("exh4", {56'd0, p4}, {56'd0, exp4_q});
      if (i < 256) begin
        a4 = i[7:4];
        b4 = i[3:0];
        exp4_q = m4(a4, b4);
      end
    end

    // random N=8, starting with the extreme corners
    exp8_q = '0;
    for (int i = 0; i <= 10000; i++) begin
      @(negedge clk);
      if (i > 0) chk("rnd8", {48'd0, p8}, {48'd0, exp8_q});
      if (i < 10000) begin
        case (i)
          0:       begin a8 = 8'h80; b8 = 8'h80; end
          1:       begin a8 = 8'h7F; b8 = 8'h80; end
          2:       begin a8 = 8'h7F; b8 = 8'h7F; end
          3:       begin a8 = 8'hFF; b8 = 8'hFF; end
          default: begin a8 = 8'($urandom); b8 = 8'($urandom); end
        endcase
        exp8_q = m8(a8, b8);
      end
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/baugh_wooley_mult.md
Name: baugh_wooley_mult

Overview:
- Signed two's-complement array multiplier using the Baugh-Wooley scheme.
- Computes p = a * b for N-bit operands and produces a full 2N-bit signed product.
- The product is registered on the output, with one clock of latency.
- Used as a small arithmetic leaf in datapaths needing signed products without a DSP primitive.

Parameters:
- N, 4, operand width in bits (N >= 2); product width is 2N.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  N  multiplicand, signed two's complement.
- b  input  N  multiplier, signed two's complement.
- p  output  2N  product, signed two's complement, registered.

Behaviour:
- Reset: rst_n low forces p = 0 immediately, independent of clk. p holds 0 while rst_n is low.
- On reset release, the first rising edge with rst_n high loads a product.
- Latency: the combinational array computes a*b from the current a and b. On every rising edge with rst_n high, p <= a*b. So p reflects the a/b present at the preceding edge (1 cycle).
- No enable or handshake: a new product is accepted every cycle (throughput 1/cycle).
- Reset mid-operation: an in-flight result is discarded and p = 0. No other state exists.
- Partial products pp[i][j] = a[j] & b[i] for i, j in 0..N-1, with these exceptions:
  - Inverted (NAND) when exactly one of i, j equals N-1.
  - pp[N-1][N-1] = a[N-1] & b[N-1] (not inverted).
- Correction constants: add 1 at bit position N and 1 at bit position 2N-1.
- Sum all terms modulo 2^2N. No overflow is possible; the full 2N-bit result is exact for all operand pairs.
- Extreme case: a = b = -2^(N-1) gives +2^(2N-2). For N=4, -8*-8 = 64 = 8'h40, which fits.
- Array structure:
  - N-1 rows of carry-save adder cells, then a final ripple-carry row.
  - No behavioural '*' operator in the array; the synthesised structure must be the Baugh-Wooley array.
- Result must be bit-exact to signed multiplication for all 2^(2N) input pairs.

Decomposition:
- Shared package holds:
  - Default width constant BW_N = 4.
  - A function bw_ref(a, b) returning the signed 2N-bit product, for assertions and scoreboards.
- Sub-module bw_cell: one array cell with inputs a_bit, b_bit, inv (select NAND vs AND), sum_in, carry_in; outputs sum_out, carry_out.
- Top level instantiates the cells with generate loops, builds the final ripple row, and holds the output register.

Test Plan:
- Reset: hold rst_n=0 with a=4'b1011, b=4'b1010 -> p=8'h00. Assert rst_n low asynchronously mid-cycle after a load -> p returns to 8'h00 without waiting for a clock edge.
- Negative x negative (each held one cycle, p checked the cycle after):
  - a=1011 (-5), b=1010 (-6) -> p=8'h1E (30).
  - a=1111, b=1111 -> p=8'h01.
  - a=1010, b=1110 -> p=8'h0C (12).
  - a=1001, b=1000 -> p=8'h38 (56).
- Zero and sign-mixed:
  - a=1000, b=0000 -> p=8'h00.
  - a=0001, b=1100 -> p=8'hFC (-4).
  - a=0010, b=1110 -> p=8'hFC (-4).
  - a=0011, b=1011 -> p=8'hF1 (-15).
  - a=0111, b=1001 -> p=8'hCF (-49).
- Extremes:
  - a=1000, b=1000 -> p=8'h40 (64).
  - a=0111, b=0111 -> p=8'h31 (49).
  - a=0111, b=1000 -> p=8'hC8 (-56).
- Back-to-back: change a/b every cycle for 20 cycles -> each p matches bw_ref of the inputs from the prior edge. No bubbles.
- Exhaustive: all 256 (a,b) pairs for N=4, plus 10k random pairs at N=8 -> zero mismatches against bw_ref.
